// File: rtl/aes_128_arbiter.sv
// Round-robin scheduler sharing one aes_128 core between N_REQ requesters, with a tagged response register.
// Optional watchdog on the in-flight block is enabled by defining AES_ARB_WDOG_EN.
module aes_128_arbiter #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ),
    parameter int WDOG_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*128-1:0] req_data,
    input  logic [N_REQ*128-1:0] req_key,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [127:0]         rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    input  logic                 core_ready,
    input  logic                 core_valid,
    input  logic [127:0]         core_out,
    output logic [127:0]         core_in,
    output logic [127:0]         core_key,
    output logic                 busy,
    output logic                 wdog_err
);

    logic            busy_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] tag_q;
    logic [ID_W-1:0] sel;
    logic [ID_W:0]   idx;
    logic            found;
    logic            capture;
    logic            grant;
    logic            wdog_expire;
    logic            rsp_valid_q;
    logic [127:0]    rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;

    assign capture = core_valid & busy_q;
    // Grant only when the output register is guaranteed free for this block's result.
    assign grant = core_ready & found & ~busy_q & ~capture & (~rsp_valid_q | rsp_ready);

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        core_in   = '0;
        core_key  = '0;
        if (grant) begin
            req_ready[sel] = 1'b1;
            core_in        = req_data[int'(sel)*128 +: 128];
            core_key       = req_key[int'(sel)*128 +: 128];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            ptr_q  <= '0;
            tag_q  <= '0;
        end else begin
            if (grant) begin
                busy_q <= 1'b1;
                tag_q  <= sel;
                ptr_q  <= (sel == ID_W'(N_REQ-1)) ? '0 : sel + ID_W'(1);
            end else if (capture || wdog_expire) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= core_out;
                rsp_id_q    <= tag_q;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef AES_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_err_q;

    // Down-counter loaded on grant; terminal count while still busy means the core never answered.
    assign wdog_expire = busy_q & ~capture & (wdog_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (grant) begin
                wdog_cnt <= WD_W'(WDOG_CYCLES - 1);
            end else if (busy_q && !capture && wdog_cnt != '0) begin
                wdog_cnt <= wdog_cnt - WD_W'(1);
            end
            if (wdog_expire) begin
                wdog_err_q <= 1'b1;
            end
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic unused_wdog;

    assign unused_wdog = (WDOG_CYCLES > 0);
    assign wdog_expire = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_aes_128_arbiter.sv
// Directed bench for aes_128_arbiter with a free-running behavioural core model (LAT-cycle period).
module tb_aes_128_arbiter;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = 4;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*128-1:0] req_data = '0;
    logic [N_REQ*128-1:0] req_key = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [127:0]         rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 core_ready;
    logic                 core_valid;
    logic [127:0]         core_out;
    logic [127:0]         core_in;
    logic [127:0]         core_key;
    logic                 busy;
    logic                 wdog_err;

    int total = 0;
    int bad = 0;

    logic [127:0] pt_tab  [N_REQ];
    logic [127:0] key_tab [N_REQ];

    always #5 clk = ~clk;

    aes_128_arbiter #(.N_REQ(N_REQ), .WDOG_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .core_ready(core_ready), .core_valid(core_valid), .core_out(core_out),
        .core_in(core_in), .core_key(core_key), .busy(busy), .wdog_err(wdog_err)
    );

    // Stand-in core: known FIPS-197 answer for the reference vector, a cheap mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == PT0 && k == K0) return CT0;
        return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a5a5a_00ff00ff_12345678_9abcdef0;
    endfunction

    int           core_cnt = 0;
    logic         core_has = 1'b0;
    logic         core_suppress = 1'b0;
    logic [127:0] core_res = '0;

    assign core_ready = (core_cnt == 0);
    assign core_valid = core_ready & core_has & ~core_suppress;
    assign core_out   = core_valid ? core_res : '0;

    always @(posedge clk) begin
        if (core_cnt == 0) begin
            core_res <= core_fn(core_in, core_key);
            core_has <= 1'b1;
            core_cnt <= LAT - 1;
        end else begin
            core_cnt <= core_cnt - 1;
        end
    end

    int grant_log[$];
    int bad_grant = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
                if (busy || !core_ready || $countones(req_ready) != 1) bad_grant++;
            end else if (core_in != '0 || core_key != '0) begin
                bad_grant++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        total++; if (rsp_id !== '0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        total++; if (busy !== 1'b0 || wdog_err !== 1'b0) begin bad++; $display("FAIL reset_busy_wdog got=%b%b exp=00", busy, wdog_err); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        total++; if (core_in !== '0 || core_key !== '0) begin bad++; $display("FAIL reset_core_bus got=%h/%h exp=0", core_in, core_key); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int k;
        int lat;
        logic [127:0] d;
        grant_log.delete();
        rsp_ready = 1'b0;
        req_data[127:0] = PT0;
        req_key[127:0]  = K0;
        req_valid = 4'b0001;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (req_ready != '0) break; end
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        total++; if (core_in !== PT0 || core_key !== K0) begin bad++; $display("FAIL single_core_bus got=%h/%h exp=%h/%h", core_in, core_key, PT0, K0); end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        lat = 1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        for (k = 0; k < 50 && !rsp_valid; k++) begin @(negedge clk); lat++; end
        total++; if (lat != LAT + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT + 1); end
        total++; if (rsp_data !== CT0) begin bad++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, CT0); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
        d = rsp_data;
        repeat (3) @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== d) begin bad++; $display("FAIL single_hold got=%b/%h exp=1/%h", rsp_valid, rsp_data, d); end
        total++; if (grant_log.size() != 1) begin bad++; $display("FAIL single_grant_count got=%0d exp=1", grant_log.size()); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int got = 0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [127:0] exp_d;
        do_reset();
        grant_log.delete();
        bad_grant = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pt_tab[i]  = {4{32'ha5a50000 | 32'(i)}};
            key_tab[i] = {4{32'h0f0f0000 | (32'(i) << 8)}};
            req_data[128*i +: 128] = pt_tab[i];
            req_key[128*i +: 128]  = key_tab[i];
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 300 && got < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                exp_d = core_fn(pt_tab[rsp_id], key_tab[rsp_id]);
                total++; if (int'(rsp_id) != exp_order[got]) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", got, rsp_id, exp_order[got]); end
                total++; if (rsp_data !== exp_d) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", got, rsp_data, exp_d); end
                got++;
            end
        end
        total++; if (got != 5) begin bad++; $display("FAIL rr_rsp_count got=%0d exp=5", got); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
                bad++; $display("FAIL rr_grant_order[%0d] got=%0d exp=%0d", i, (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            end
        end
        total++; if (bad_grant != 0) begin bad++; $display("FAIL rr_bad_grant got=%0d exp=0", bad_grant); end
    endtask

    task automatic test_backpressure();
        int k;
        int n;
        int unstable = 0;
        logic [127:0] d;
        logic [ID_W-1:0] id;
        rsp_ready = 1'b0;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (rsp_valid) break; end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_seen got=%b exp=1", rsp_valid); end
        d = rsp_data;
        id = rsp_id;
        n = grant_log.size();
        repeat (100) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d || rsp_id !== id) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        total++; if (grant_log.size() != n) begin bad++; $display("FAIL bp_no_grant got=%0d exp=%0d", grant_log.size(), n); end
        rsp_ready = 1'b1;
        #1;
        for (k = 0; k < 2 * LAT && !core_ready; k++) begin @(negedge clk); #1; end
        total++; if (req_ready == '0 || !core_ready) begin bad++; $display("FAIL bp_resume_grant got=%b exp=onehot", req_ready); end
    endtask

    task automatic test_idle();
        int k;
        int viol = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (!busy && !rsp_valid) break; end
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_drain got=%b%b exp=00", busy, rsp_valid); end
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid || core_in != '0 || core_key != '0 || req_ready != '0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL idle_quiet got=%0d exp=0", viol); end
    endtask

    task automatic test_reset_mid();
        int k;
        int viol = 0;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (req_ready != '0) break; end
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmid_grant got=%b exp=0100", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", busy); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) begin
            bad++; $display("FAIL rmid_async_clear got=%b%b/%h/%0d exp=00/0/0", busy, rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * LAT) begin
            @(negedge clk);
            if (rsp_valid || busy) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL rmid_stale_valid got=%0d exp=0", viol); end
    endtask

`ifdef AES_ARB_WDOG_EN
    task automatic test_wdog();
        int k;
        logic [127:0] exp_d;
        do_reset();
        rsp_ready = 1'b1;
        core_suppress = 1'b1;
        req_valid = 4'b0010;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (req_ready != '0) break; end
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wdog_grant got=%b exp=0010", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        repeat (8) @(negedge clk);
        total++; if (wdog_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wdog_early got=%b%b exp=01", wdog_err, busy); end
        @(negedge clk);
        total++; if (wdog_err !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL wdog_fire got=%b%b%b exp=100", wdog_err, busy, rsp_valid);
        end
        core_suppress = 1'b0;
        req_valid = 4'b1000;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (req_ready != '0) break; end
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wdog_next_grant got=%b exp=1000", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (rsp_valid) break; end
        exp_d = core_fn(pt_tab[3], key_tab[3]);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== exp_d) begin
            bad++; $display("FAIL wdog_next_rsp got=%b/%0d/%h exp=1/3/%h", rsp_valid, rsp_id, rsp_data, exp_d);
        end
        total++; if (wdog_err !== 1'b1) begin bad++; $display("FAIL wdog_sticky got=%b exp=1", wdog_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_idle();
        test_reset_mid();
`ifdef AES_ARB_WDOG_EN
        test_wdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
